// File: rtl/bp_btb.sv
// bp_btb: direct-mapped branch target buffer with a 2-bit saturating
// counter per entry.
//  - Zero-latency lookup on the fetch PC gives the predicted next PC.
//  - Resolved branches/jumps from EX train the table.
//  - Resolved branches/jumps also raise mispredict/redirect_pc when the
//    carried prediction was wrong.
// Optional feature macro: BP_PERF_CNT_EN adds perf_clr and three 32-bit
// performance counters (perf_lookups, perf_updates, perf_mispredicts).
module bp_btb #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_jump,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc
`ifdef BP_PERF_CNT_EN
    ,
    input  logic            perf_clr,
    output logic [31:0]     perf_lookups,
    output logic [31:0]     perf_updates,
    output logic [31:0]     perf_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

    // Entry storage
    logic             valid_r  [ENTRIES];
    logic [TAG_W-1:0] tag_r    [ENTRIES];
    logic [XLEN-1:0]  target_r [ENTRIES];
    logic             jump_r   [ENTRIES];
    logic [1:0]       ctr_r    [ENTRIES];

    logic [IDX_W-1:0] lk_idx_s;
    logic [TAG_W-1:0] lk_tag_s;
    logic             lk_hit_s;
    logic [IDX_W-1:0] up_idx_s;
    logic [TAG_W-1:0] up_tag_s;
    logic             up_hit_s;

    logic             wr_en_s;
    logic [TAG_W-1:0] nx_tag_s;
    logic [XLEN-1:0]  nx_target_s;
    logic             nx_jump_s;
    logic [1:0]       nx_ctr_s;

    assign lk_idx_s = if_pc[IDX_W+1:2];
    assign lk_tag_s = if_pc[XLEN-1:IDX_W+2];
    assign up_idx_s = upd_pc[IDX_W+1:2];
    assign up_tag_s = upd_pc[XLEN-1:IDX_W+2];

    // Same-cycle lookup; reads pre-edge contents (no write-through bypass).
    always_comb begin
        lk_hit_s    = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
        pred_taken  = lk_hit_s && (jump_r[lk_idx_s] || ctr_r[lk_idx_s][1]);
        if (pred_taken) begin
            pred_target = target_r[lk_idx_s];
        end else begin
            pred_target = if_pc + PC_STEP;
        end
    end

    // Mispredict detection against the prediction carried with the instruction.
    always_comb begin
        if (upd_valid) begin
            mispredict = (upd_taken != upd_pred_taken) ||
                         (upd_taken && upd_pred_taken && (upd_target != upd_pred_target));
        end else begin
            mispredict = 1'b0;
        end
        if (upd_taken) begin
            redirect_pc = upd_target;
        end else begin
            redirect_pc = upd_pc + PC_STEP;
        end
    end

    // Next contents of the entry addressed by upd_pc.
    always_comb begin
        up_hit_s    = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
        wr_en_s     = 1'b0;
        nx_tag_s    = tag_r[up_idx_s];
        nx_target_s = target_r[up_idx_s];
        nx_jump_s   = jump_r[up_idx_s];
        nx_ctr_s    = ctr_r[up_idx_s];
        if (upd_valid && up_hit_s) begin
            wr_en_s = 1'b1;
            if (upd_is_jump) begin
                nx_ctr_s    = 2'd3;
                nx_target_s = upd_target;
                nx_jump_s   = 1'b1;
            end else if (upd_taken) begin
                nx_target_s = upd_target;
                if (ctr_r[up_idx_s] != 2'd3) begin
                    nx_ctr_s = ctr_r[up_idx_s] + 2'd1;
                end else begin
                    nx_ctr_s = 2'd3;
                end
            end else begin
                if (ctr_r[up_idx_s] != 2'd0) begin
                    nx_ctr_s = ctr_r[up_idx_s] - 2'd1;
                end else begin
                    nx_ctr_s = 2'd0;
                end
            end
        end else if (upd_valid && upd_taken) begin
            // Allocate or replace on a taken miss; branches start weakly taken.
            wr_en_s     = 1'b1;
            nx_tag_s    = up_tag_s;
            nx_target_s = upd_target;
            nx_jump_s   = upd_is_jump;
            nx_ctr_s    = upd_is_jump ? 2'd3 : 2'd2;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Table state: asynchronous clear, single write port per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                target_r[i] <= '0;
                jump_r[i]   <= 1'b0;
                ctr_r[i]    <= 2'd1;
            end
        end else if (wr_en_s) begin
            valid_r[up_idx_s]  <= 1'b1;
            tag_r[up_idx_s]    <= nx_tag_s;
            target_r[up_idx_s] <= nx_target_s;
            jump_r[up_idx_s]   <= nx_jump_s;
            ctr_r[up_idx_s]    <= nx_ctr_s;
        end
    end

`ifdef BP_PERF_CNT_EN
    // Event counters; clear wins over increment, all wrap at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_lookups     <= 32'd0;
            perf_updates     <= 32'd0;
            perf_mispredicts <= 32'd0;
        end else if (perf_clr) begin
            perf_lookups     <= 32'd0;
            perf_updates     <= 32'd0;
            perf_mispredicts <= 32'd0;
        end else begin
            perf_lookups     <= perf_lookups + {31'd0, pred_taken};
            perf_updates     <= perf_updates + {31'd0, upd_valid};
            perf_mispredicts <= perf_mispredicts + {31'd0, mispredict};
        end
    end
`endif

endmodule

// File: tb/tb_bp_btb.sv
// Randomised self-checking bench for bp_btb against a table-level
// reference model of the BTB rules (directed test-plan cases first).
module tb_bp_btb;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_PERF_CNT_EN
    logic        perf_clr;
    logic [31:0] perf_lookups;
    logic [31:0] perf_updates;
    logic [31:0] perf_mispredicts;
    logic [31:0] m_lookups, m_updates, m_mispredicts;
`endif

    bp_btb #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BP_PERF_CNT_EN
        , .perf_clr(perf_clr), .perf_lookups(perf_lookups),
        .perf_updates(perf_updates), .perf_mispredicts(perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference table, one slot per index
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    bit          m_jump  [ENTRIES];
    int          m_ctr   [ENTRIES];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 32'd16);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 32'd0; m_tgt[i] = 32'd0;
            m_jump[i] = 1'b0;  m_ctr[i] = 1;
        end
`ifdef BP_PERF_CNT_EN
        m_lookups = 32'd0; m_updates = 32'd0; m_mispredicts = 32'd0;
`endif
    endtask

    task automatic model_predict(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int  i;
        bit  hit;
        i   = idx_of(pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        tk  = hit && (m_jump[i] || m_ctr[i] >= 2);
        tg  = tk ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic model_update(input logic [31:0] pc, input logic jmp, input logic tk,
                                input logic [31:0] tg);
        int i;
        bit hit;
        i   = idx_of(pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        if (hit) begin
            if (jmp) begin
                m_ctr[i] = 3; m_tgt[i] = tg; m_jump[i] = 1'b1;
            end else if (tk) begin
                m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = tg;
            end else begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (tk) begin
            m_valid[i] = 1'b1; m_tag[i] = tag_of(pc); m_tgt[i] = tg;
            m_jump[i] = jmp;   m_ctr[i] = jmp ? 3 : 2;
        end
    endtask

    // One clock cycle: drive, check combinational outputs, clock, train model.
    task automatic step(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                        input logic ujmp, input logic utk, input logic [31:0] utg,
                        input logic uptk, input logic [31:0] uptg, input logic clr);
        logic        e_tk;
        logic [31:0] e_tg;
        logic        e_mp;
        if_pc = pc; upd_valid = uv; upd_pc = upc; upd_is_jump = ujmp;
        upd_taken = utk; upd_target = utg; upd_pred_taken = uptk; upd_pred_target = uptg;
`ifdef BP_PERF_CNT_EN
        perf_clr = clr;
`endif
        #1;
        model_predict(pc, e_tk, e_tg);
        e_mp = uv && ((utk != uptk) || (utk && uptk && utg != uptg));
        check_val("pred_taken", {31'd0, pred_taken}, {31'd0, e_tk});
        check_val("pred_target", pred_target, e_tg);
        check_val("mispredict", {31'd0, mispredict}, {31'd0, e_mp});
        if (uv) check_val("redirect_pc", redirect_pc, utk ? utg : upc + 32'd4);
        @(posedge clk);
        if (uv) model_update(upc, ujmp, utk, utg);
`ifdef BP_PERF_CNT_EN
        if (clr) begin
            m_lookups = 32'd0; m_updates = 32'd0; m_mispredicts = 32'd0;
        end else begin
            m_lookups     = m_lookups + {31'd0, e_tk};
            m_updates     = m_updates + {31'd0, uv};
            m_mispredicts = m_mispredicts + {31'd0, e_mp};
        end
`endif
        #1;
`ifdef BP_PERF_CNT_EN
        check_val("perf_lookups", perf_lookups, m_lookups);
        check_val("perf_updates", perf_updates, m_updates);
        check_val("perf_mispredicts", perf_mispredicts, m_mispredicts);
`endif
    endtask

    // Lookup only, no clock edge crossed; expectations are fixed constants.
    task automatic expect_lookup(input string tag, input logic [31:0] pc,
                                 input logic e_tk, input logic [31:0] e_tg);
        if_pc = pc; upd_valid = 1'b0;
        #1;
        check_val({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, e_tk});
        check_val({tag, "_target"}, pred_target, e_tg);
    endtask

    task automatic random_step();
        logic [31:0] base, pc, upc, utg, uptg;
        logic        ujmp, utk, uptk, mtk;
        base = ($urandom_range(0, 3) == 0) ? 32'hFFFFF000 : 32'h0;
        upc  = base | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
        pc   = ($urandom_range(0, 3) == 0) ? upc
             : ((32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2));
        ujmp = ($urandom_range(0, 4) == 0);
        utk  = ujmp ? 1'b1 : 1'($urandom_range(0, 1));
        utg  = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
        model_predict(upc, mtk, uptg);
        uptk = mtk;
        if ($urandom_range(0, 3) == 0) begin
            uptk = 1'($urandom_range(0, 1));
            uptg = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
        end
        step(pc, 1'($urandom_range(0, 5) != 0), upc, ujmp, utk, utg, uptk, uptg,
             ($urandom_range(0, 49) == 0));
    endtask

    initial begin
        reset = 1'b0; if_pc = 32'h100; upd_valid = 1'b0; upd_pc = 32'd0;
        upd_is_jump = 1'b0; upd_taken = 1'b0; upd_target = 32'd0;
        upd_pred_taken = 1'b0; upd_pred_target = 32'd0;
`ifdef BP_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        model_reset();
        #2;
        expect_lookup("reset_lookup", 32'h100, 1'b0, 32'h104);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Taken branch at 0x100 -> 0x80, predicted not taken
        step(32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0);
        expect_lookup("alloc", 32'h100, 1'b1, 32'h80);
        // Two not-taken resolutions: ctr 2->1->0
        step(32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80, 1'b0);
        expect_lookup("ctr1", 32'h100, 1'b0, 32'h104);
        step(32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0);
        expect_lookup("ctr0", 32'h100, 1'b0, 32'h104);
        // jal 0x200 -> 0x400, then retarget to 0x500
        step(32'h200, 1'b1, 32'h200, 1'b1, 1'b1, 32'h400, 1'b0, 32'h204, 1'b0);
        expect_lookup("jal", 32'h200, 1'b1, 32'h400);
        upd_valid = 1'b1; upd_pc = 32'h200; upd_is_jump = 1'b1; upd_taken = 1'b1;
        upd_target = 32'h500; upd_pred_taken = 1'b1; upd_pred_target = 32'h400;
        #1;
        check_val("retarget_mispredict", {31'd0, mispredict}, 32'd1);
        check_val("retarget_redirect", redirect_pc, 32'h500);
        step(32'h200, 1'b1, 32'h200, 1'b1, 1'b1, 32'h500, 1'b1, 32'h400, 1'b0);
        expect_lookup("retarget", 32'h200, 1'b1, 32'h500);
        // Aliasing: 0x140 shares idx 0 with 0x100; same-cycle lookup sees old entry
        step(32'h140, 1'b1, 32'h140, 1'b0, 1'b1, 32'h300, 1'b0, 32'h144, 1'b0);
        expect_lookup("alias_old", 32'h100, 1'b0, 32'h104);
        expect_lookup("alias_new", 32'h140, 1'b1, 32'h300);
        // PC+4 wraps at the top of the address space
        expect_lookup("wrap", 32'hFFFFFFFC, 1'b0, 32'h00000000);

        for (int n = 0; n < 1500; n++) random_step();

        // Asynchronous reset mid-cycle, with an update in flight
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_is_jump = 1'b0;
        #2 reset = 1'b0;
        #1;
`ifdef BP_PERF_CNT_EN
        check_val("rst_perf_lookups", perf_lookups, 32'd0);
        check_val("rst_perf_updates", perf_updates, 32'd0);
        check_val("rst_perf_mispredicts", perf_mispredicts, 32'd0);
`endif
        for (int i = 0; i < ENTRIES; i++) begin
            logic [31:0] pc;
            pc = (m_tag[i] << 6) | (32'(i) << 2);
            expect_lookup("rst_miss", pc, 1'b0, pc + 32'd4);
        end
        model_reset();
        upd_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        for (int n = 0; n < 300; n++) random_step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
